sev_read_responder: RTL

Memory-side read responder for the SEV encryption path: accepts tagged read requests from the core/LSU side, fetches ciphertext from memory, and returns plaintext by XORing with the requesting VM's 64-bit key. It sits between the cache fill path and the memory port and holds a per-ASID key table programmed by the hypervisor/PSP. One transaction is outstanding at a time; requests with no programmed key are answered with an error and no memory access.

---
 rtl/sev_read_responder.sv | 92 +++++++++
 1 files changed

// File: rtl/sev_read_responder.sv
// SEV read responder: fetches ciphertext for one tagged read at a time and
// returns plaintext by XORing it with the requesting VM's key from a per-ASID table.
module sev_read_responder #(
   parameter int ASID_W = 4,
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_we_i,
   input  logic              key_inv_i,
   input  logic [ASID_W-1:0] key_asid_i,
   input  logic [63:0]       key_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [ASID_W-1:0] req_asid_i,
   output logic              mem_req_valid_o,
   input  logic              mem_req_ready_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_resp_valid_i,
   input  logic [63:0]       mem_resp_data_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [63:0]       resp_data_o,
   output logic              resp_err_o
);

   localparam int ENTRIES = 1 << ASID_W;

   typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;

   state_t              state;
   logic [63:0]         key_tab [ENTRIES];
   logic [ENTRIES-1:0]  key_vld;
   logic [ADDR_W-1:0]   addr;
   logic [63:0]         key;
   logic [63:0]         resp_data;
   logic                resp_err;

   // Table writes land at the edge, so a same-cycle request reads the old entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) key_tab[i] <= '0;
         key_vld <= '0;
      end else if (key_we_i) begin
         key_tab[key_asid_i] <= key_i;
         key_vld[key_asid_i] <= 1'b1;
      end else if (key_inv_i) begin
         key_vld[key_asid_i] <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         key       <= '0;
         resp_data <= '0;
         resp_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid_i) begin
               addr <= req_addr_i;
               key  <= key_tab[req_asid_i];
               if (key_vld[req_asid_i]) begin
                  state <= MEM_REQ;
               end else begin
                  resp_data <= '0;
                  resp_err  <= 1'b1;
                  state     <= RESP;
               end
            end
            MEM_REQ:  if (mem_req_ready_i) state <= MEM_WAIT;
            MEM_WAIT: if (mem_resp_valid_i) begin
               resp_data <= mem_resp_data_i ^ key;
               resp_err  <= 1'b0;
               state     <= RESP;
            end
            RESP:     if (resp_ready_i) state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign req_ready_o     = (state == IDLE);
   assign mem_req_valid_o = (state == MEM_REQ);
   assign mem_addr_o      = addr;
   assign resp_valid_o    = (state == RESP);
   assign resp_data_o     = resp_data;
   assign resp_err_o      = resp_err;

endmodule
